// File: rtl/cpu_defs_pkg.sv
// Shared MIPS core definitions: result classes, operand-use timing and
// default forwarding/latency constants used by the hazard logic.
package cpu_defs_pkg;

   typedef enum logic [1:0] {
      RES_NW  = 2'b00,
      RES_ALU = 2'b01,
      RES_DM  = 2'b10,
      RES_PC  = 2'b11
   } res_t;

   typedef enum logic [1:0] {
      TUSE_ID   = 2'd0,
      TUSE_EX   = 2'd1,
      TUSE_MEM  = 2'd2,
      TUSE_NONE = 2'd3
   } tuse_t;

   localparam int NSTAGE_DEF   = 3;
   localparam int ALU_RDY_DEF  = 2;
   localparam int DM_RDY_DEF   = 3;
   localparam int PC_RDY_DEF   = 1;
   localparam int MULT_LAT_DEF = 5;
   localparam int DIV_LAT_DEF  = 10;

   typedef struct packed {
      logic       valid;
      logic [4:0] dst;
      res_t       res;
   } entry_t;

   // Stage index at which a result of the given class can be forwarded.
   function automatic int rdy_of(input res_t res, input int alu_rdy,
                                 input int dm_rdy, input int pc_rdy);
      case (res)
         RES_ALU: return alu_rdy;
         RES_DM:  return dm_rdy;
         RES_PC:  return pc_rdy;
         default: return 0;
      endcase
   endfunction

endpackage

// File: rtl/hazard_match.sv
// Youngest-match resolver for one source register against a range of
// in-flight entries; yields the forwarding select and a "too late" flag.
module hazard_match
   import cpu_defs_pkg::*;
#(
   parameter int NSTAGE  = NSTAGE_DEF,
   parameter int FIRST   = 1,
   parameter int ALU_RDY = ALU_RDY_DEF,
   parameter int DM_RDY  = DM_RDY_DEF,
   parameter int PC_RDY  = PC_RDY_DEF,
   parameter int SELW    = $clog2(NSTAGE + 1)
) (
   input  logic            en,
   input  logic [4:0]      r,
   input  logic [1:0]      tuse,
   input  entry_t          ents [1:NSTAGE],
   output logic            late,
   output logic [SELW-1:0] sel
);

   int rdy;

   // Scan oldest to youngest so the youngest match is the one left standing;
   // an older ready producer can never mask a younger unready one.
   always_comb begin
      // NOTE: every output gets a default before the loop, otherwise
      // paths with no match would infer latches.
      late = 1'b0;
      sel  = '0;
      rdy  = 0;
      for (int k = NSTAGE; k >= FIRST; k--) begin
         if (en && r != 5'd0 && ents[k].valid && ents[k].res != RES_NW &&
             ents[k].dst == r) begin
            rdy = rdy_of(ents[k].res, ALU_RDY, DM_RDY, PC_RDY);
            if (rdy > k) begin
               sel  = '0;
               late = (tuse != TUSE_NONE) && ((rdy - k) > int'(tuse));
            end else begin
               sel  = SELW'(k);
               late = 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding unit: tracks EX..WB destinations, derives the decode
// stall and ID/EX forwarding selects, and times the multi-cycle MD unit.
module hazard_scoreboard
   import cpu_defs_pkg::*;
#(
   parameter int NSTAGE   = NSTAGE_DEF,
   parameter int ALU_RDY  = ALU_RDY_DEF,
   parameter int DM_RDY   = DM_RDY_DEF,
   parameter int PC_RDY   = PC_RDY_DEF,
   parameter int MULT_LAT = MULT_LAT_DEF,
   parameter int DIV_LAT  = DIV_LAT_DEF,
   localparam int SELW    = $clog2(NSTAGE + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            id_valid,
   input  logic [4:0]      id_rs,
   input  logic [4:0]      id_rt,
   input  logic [1:0]      id_tuse_rs,
   input  logic [1:0]      id_tuse_rt,
   input  logic [4:0]      id_dst,
   input  logic [1:0]      id_res,
   input  logic            id_md_use,
   input  logic            id_md_start,
   input  logic            id_md_div,
   input  logic            flush,
   output logic            stall,
   output logic [SELW-1:0] fwd_id_rs,
   output logic [SELW-1:0] fwd_id_rt,
   output logic [SELW-1:0] fwd_ex_rs,
   output logic [SELW-1:0] fwd_ex_rt,
   output logic            md_busy
);

   localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int MDW     = $clog2(MAX_LAT + 1);

   entry_t         e [1:NSTAGE];
   logic [4:0]     e1_rs, e1_rt;
   logic [MDW-1:0] md_cnt;
   logic           late_rs, late_rt, late_ex_rs, late_ex_rt;
   logic           load;
   logic           unused_ex_late;

   hazard_match #(.NSTAGE(NSTAGE), .FIRST(1), .ALU_RDY(ALU_RDY), .DM_RDY(DM_RDY),
                  .PC_RDY(PC_RDY), .SELW(SELW))
   u_id_rs (.en(1'b1), .r(id_rs), .tuse(id_tuse_rs), .ents(e), .late(late_rs), .sel(fwd_id_rs));

   hazard_match #(.NSTAGE(NSTAGE), .FIRST(1), .ALU_RDY(ALU_RDY), .DM_RDY(DM_RDY),
                  .PC_RDY(PC_RDY), .SELW(SELW))
   u_id_rt (.en(1'b1), .r(id_rt), .tuse(id_tuse_rt), .ents(e), .late(late_rt), .sel(fwd_id_rt));

   // EX operands are already being consumed, so they only select, never stall.
   hazard_match #(.NSTAGE(NSTAGE), .FIRST(2), .ALU_RDY(ALU_RDY), .DM_RDY(DM_RDY),
                  .PC_RDY(PC_RDY), .SELW(SELW))
   u_ex_rs (.en(e[1].valid), .r(e1_rs), .tuse(TUSE_NONE), .ents(e), .late(late_ex_rs),
            .sel(fwd_ex_rs));

   hazard_match #(.NSTAGE(NSTAGE), .FIRST(2), .ALU_RDY(ALU_RDY), .DM_RDY(DM_RDY),
                  .PC_RDY(PC_RDY), .SELW(SELW))
   u_ex_rt (.en(e[1].valid), .r(e1_rt), .tuse(TUSE_NONE), .ents(e), .late(late_ex_rt),
            .sel(fwd_ex_rt));

   assign unused_ex_late = late_ex_rs | late_ex_rt;

   assign md_busy = (md_cnt != '0);
   assign stall   = id_valid && (late_rs || late_rt || (id_md_use && md_busy)) && !flush;
   assign load    = id_valid && !stall && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the entry array is a handful of flops whose valid bits must
         // come up clear, so the whole array is reset rather than left as RAM.
         for (int k = 1; k <= NSTAGE; k++) e[k] <= '0;
         e1_rs  <= '0;
         e1_rt  <= '0;
         md_cnt <= '0;
      end else begin
         // NOTE: non-blocking assignments let every stage read the pre-edge
         // value of its neighbour, which is what makes this a shift register.
         e[1]  <= load ? '{valid: 1'b1, dst: id_dst, res: res_t'(id_res)} : '0;
         e1_rs <= id_rs;
         e1_rt <= id_rt;
         for (int k = 2; k <= NSTAGE; k++)
            e[k] <= (k == 2 && flush) ? '0 : e[k-1];

         // A flush leaves the counter alone so an issued MD operation completes.
         if (load && id_md_start)
            md_cnt <= id_md_div ? MDW'(DIV_LAT) : MDW'(MULT_LAT);
         else if (md_busy)
            md_cnt <= md_cnt - 1'b1;
      end
   end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding unit for the pipelined MIPS core. It tracks every in-flight instruction from EX to WB in an internal shift register of {valid, destination, result class} entries. Each cycle it generates the decode-stage stall, and forwarding selects for both the ID-stage and EX-stage source operands. A latency counter for the multi-cycle mult/div unit stalls HI/LO users while that unit is busy.

## Interface
Parameters:
- NSTAGE, 3: tracked post-decode stages (1=EX, 2=MEM, 3=WB, ...).
- ALU_RDY, 2: stage index at which an ALU result becomes forwardable.
- DM_RDY, 3: stage index for load and mfc0 results.
- PC_RDY, 1: stage index for link (jal/jalr) results.
- MULT_LAT, 5: busy cycles for mult/multu.
- DIV_LAT, 10: busy cycles for div/divu.
- Constraint: 1 ≤ every *_RDY ≤ NSTAGE.
- SELW = $clog2(NSTAGE+1), derived.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  5  source register numbers.
- id_tuse_rs, id_tuse_rt  in  2  cycles until the operand is consumed (0=ID, 1=EX, 2=MEM, 3=unused).
- id_dst  in  5  destination register.
- id_res  in  2  result class: NW=00, ALU=01, DM=10, PC=11.
- id_md_use  in  1  instruction needs an idle MD unit (mult/div/mfhi/mflo/mthi/mtlo).
- id_md_start  in  1  instruction starts MD.
- id_md_div  in  1  the start is a divide.
- flush  in  1  exception/eret flush of ID and EX.
- stall  out  1  freeze PC and IF/ID; insert a bubble into EX.
- fwd_id_rs, fwd_id_rt  out  SELW  ID-stage forwarding source: 0=register file, k=stage k.
- fwd_ex_rs, fwd_ex_rt  out  SELW  EX-stage forwarding source, same encoding.
- md_busy  out  1  MD counter is nonzero.

## Operation
- **Entries.** There are NSTAGE entries, e[1..NSTAGE]; e[1] also stores rs and rt.
- **RDY(res)** is ALU_RDY, DM_RDY or PC_RDY according to the result class.
- **Match.** Entry k matches register r when e[k].valid, e[k].res≠NW, e[k].dst==r and r≠0. Register 0 never matches, never stalls, and always selects 0.
- **tnew(k)** = max(0, RDY(res) − k).
- **Data stall, per source with tuse≠3.** Take the youngest matching k (smallest k). Stall when tnew(k) > tuse.
- **MD stall.** Stall when id_md_use && md_busy.
- **Stall output.** stall = id_valid && (rs stall | rt stall | MD stall) && !flush.
- **ID forwarding.** fwd_id_x = k when the youngest match k has k ≥ RDY(res); otherwise 0. An older ready match never overrides a younger unready one.
- **EX forwarding.** fwd_ex_x applies the same rule using e[1].rs/rt against e[2..NSTAGE]. The result is 0 when e[1] is invalid.
- **Shift, each cycle.** e[k+1] ← e[k] for all k.
- **Loading e[1].**
  - e[1] ← ID instruction when id_valid && !stall && !flush.
  - e[1] ← bubble (valid=0) otherwise.
- **Flush.** Also invalidates the outgoing e[1]: e[2] receives a bubble. Entries in e[2..NSTAGE] still shift normally.
- **MD counter.**
  - Loads MULT_LAT or DIV_LAT when id_md_start && id_valid && !stall && !flush.
  - Otherwise decrements when nonzero.
  - Flush does not clear it: an in-flight MD operation completes.

## Timing
- Reset (async assert): all entries invalid and counter 0. Therefore stall=0, every fwd_*=0 and md_busy=0.
- Release of rst_n is synchronised externally; the block needs no reset sequencing.
- stall and all fwd_* are combinational from the inputs and the current entries; they settle within the cycle.
- **Load-use.** A load immediately followed by a tuse=0 consumer produces 2 stall cycles. The consumer then sees fwd_id=3 (WB).
- **Load then tuse=1 consumer.** 1 stall cycle, then fwd_ex=3.
- **md_busy** rises the cycle after issue and stays high for exactly LAT cycles.
- **Simultaneous stall and flush.** Flush wins: stall=0 and a bubble enters EX.
- **MD start with busy high.** Stalls; the counter is not reloaded.

## Structure
- Shared package `cpu_defs_pkg` holds:
  - result class encodings NW/ALU/DM/PC;
  - the tuse encoding;
  - the default RDY and latency constants.
- One natural sub-module, `hazard_match`, a combinational youngest-match and select resolver. It is instantiated four times (id rs/rt, ex rs/rt).
- The entry pipeline and the MD counter live in the top module.

## Test plan
- **Back-to-back ALU.** addu $3 → addu $4,$3 with tuse=1 → stall=0; then fwd_ex_rs=2.
- **Load-use.** lw $5 → addu using $5 with tuse=0 → stall high for exactly 2 cycles; then fwd_id_rs=3.
- **Youngest wins.** ori $6, then lw $6, then a consumer of $6 with tuse=1 → the consumer stalls on the lw for 1 cycle. The older ori in stage 2 is never selected.
- **Register 0.** A consumer of $0 behind jal writing $0 → stall=0 and fwd_*=0.
- **MD.** div, then mflo one cycle later → stall held for 10 cycles; md_busy falls on cycle 11 after div issue; mflo proceeds.
- **Flush.** flush asserted while a stalled load-use pair is in flight → stall=0 that cycle and e[2] is invalid next cycle. Asserting rst_n=0 mid-stall clears stall and md_busy immediately.
